// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test harness.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_W       = 2;
    localparam int unsigned ERR_W       = 3;

    localparam logic [NUM_VECTORS-1:0] TT_AND = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] TT_OR  = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] TT_XOR = 4'b0110;

    // Expected gate output for input pair {a,b} = vec.
    function automatic logic expected_out(input logic [NUM_VECTORS-1:0] tt,
                                          input logic [VEC_W-1:0]       vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter timing how long each vector is held before sampling.
module settle_counter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int unsigned          CW     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]        RELOAD = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // zero is registered alongside the count so it is valid on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= RELOAD;
            zero <= (RELOAD == '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            zero <= (cnt == CW'(1));
        end
    end

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip exhaustive checker for a 2-input combinational gate sharing clk.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0] TRUTH_TABLE   = TT_AND
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_e           state;
    logic [VEC_W-1:0] vec_idx;
    logic             zero;

    logic             mismatch_c;
    logic [ERR_W-1:0] err_next_c;
    logic             load_c;

    assign mismatch_c = (dut_out != expected_out(TRUTH_TABLE, vec_idx));
    assign err_next_c = err_count + ERR_W'(mismatch_c);
    // Reload on run entry and after every non-final sample.
    assign load_c     = ((state == IDLE) && start) ||
                        ((state == RUN) && zero && (vec_idx != LAST_VEC));

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .zero (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            vec_idx          <= '0;
            dut_a            <= 1'b0;
            dut_b            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= RUN;
                        vec_idx          <= '0;
                        dut_a            <= 1'b0;
                        dut_b            <= 1'b0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end

                RUN: begin
                    if (zero) begin
                        if (mismatch_c) begin
                            err_count <= err_next_c;
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec_idx;
                            end
                        end
                        // Final compare and verdict share the RUN->DONE edge.
                        if (vec_idx == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0);
                            dut_a <= 1'b0;
                            dut_b <= 1'b0;
                        end else begin
                            vec_idx          <= vec_idx + VEC_W'(1);
                            {dut_a, dut_b}   <= vec_idx + VEC_W'(1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench: three harness instances (AND/S=2, OR/S=2, AND/S=1) driving modelled gates.
module tb_gate_bist_checker;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] start;
    logic [3:0] dtt [3];
    wire  [2:0] da, db, dout, busy, done, pass, ffv;
    wire  [8:0] errc_all;
    wire  [5:0] ffvec_all;

    int ncmp  = 0;
    int nfail = 0;
    int cur   = 0;

    int          s_of  [3];
    logic [3:0]  tt_of [3];

    assign dout[0] = dtt[0][{da[0], db[0]}];
    assign dout[1] = dtt[1][{da[1], db[1]}];
    assign dout[2] = dtt[2][{da[2], db[2]}];

    gate_bist_checker #(.SETTLE_CYCLES(2), .TRUTH_TABLE(TT_AND)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .dut_a(da[0]), .dut_b(db[0]),
        .dut_out(dout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc_all[2:0]), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec_all[1:0]));

    gate_bist_checker #(.SETTLE_CYCLES(2), .TRUTH_TABLE(TT_OR)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .dut_a(da[1]), .dut_b(db[1]),
        .dut_out(dout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc_all[5:3]), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec_all[3:2]));

    gate_bist_checker #(.SETTLE_CYCLES(1), .TRUTH_TABLE(TT_AND)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .dut_a(da[2]), .dut_b(db[2]),
        .dut_out(dout[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(errc_all[8:6]), .first_fail_valid(ffv[2]), .first_fail_vec(ffvec_all[5:4]));

    typedef struct {
        int         inst;
        logic [3:0] dtt;
        int         e_err;
        int         e_ffv;
        int         e_vec;
        int         e_pass;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, cur, $time, act, exp);
        end
    endtask

    function automatic int errc(input int i);
        return int'(errc_all[3*i +: 3]);
    endfunction

    function automatic int ffvec(input int i);
        return int'(ffvec_all[2*i +: 2]);
    endfunction

    // Reference verdict: every table/gate disagreement is one error; first is the lowest {a,b}.
    task automatic model(input logic [3:0] tt, input logic [3:0] gate,
                         output int err, output int fv, output int vec, output int ps);
        logic [3:0] m;
        m   = tt ^ gate;
        err = 0; fv = 0; vec = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                err++;
                if (fv == 0) begin
                    fv  = 1;
                    vec = k;
                end
            end
        end
        ps = (err == 0) ? 1 : 0;
    endtask

    task automatic launch(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    // Called just after the accepting edge E0; returns just after E0+4S+1.
    task automatic check_run(input int i, input int e_err, input int e_ffv,
                             input int e_vec, input int e_pass, input bit repulse);
        int s;
        s   = s_of[i];
        cur = i;
        for (int j = 0; j < 4 * s; j++) begin
            chk("vector", int'({da[i], db[i]}), j / s);
            chk("busy_run", int'(busy[i]), 1);
            chk("done_run", int'(done[i]), 0);
            if (repulse && j == 1) start[i] = 1'b1;
            if (repulse && j == 2) start[i] = 1'b0;
            @(posedge clk); #1;
        end
        chk("done_pulse", int'(done[i]), 1);
        chk("busy_done", int'(busy[i]), 0);
        chk("vector_done", int'({da[i], db[i]}), 0);
        chk("pass", int'(pass[i]), e_pass);
        chk("err_count", errc(i), e_err);
        chk("ffv", int'(ffv[i]), e_ffv);
        chk("ffvec", ffvec(i), e_vec);
        if (repulse) start[i] = 1'b1;
        @(posedge clk); #1;
        chk("done_clear", int'(done[i]), 0);
        chk("busy_after", int'(busy[i]), 0);
        if (repulse) start[i] = 1'b0;
    endtask

    task automatic chk_all_zero(input int i, input string tag);
        cur = i;
        chk({tag, "_ab"}, int'({da[i], db[i]}), 0);
        chk({tag, "_busy"}, int'(busy[i]), 0);
        chk({tag, "_done"}, int'(done[i]), 0);
        chk({tag, "_pass"}, int'(pass[i]), 0);
        chk({tag, "_err"}, errc(i), 0);
        chk({tag, "_ffv"}, int'(ffv[i]), 0);
        chk({tag, "_ffvec"}, ffvec(i), 0);
    endtask

    initial begin
        int e_err, e_ffv, e_vec, e_pass, idx;
        logic [3:0] g;

        s_of[0] = 2; s_of[1] = 2; s_of[2] = 1;
        tt_of[0] = 4'b1000; tt_of[1] = 4'b1110; tt_of[2] = 4'b1000;

        tbl[0] = '{0, 4'b1000, 0, 0, 0, 1};  // and_gate, AND table
        tbl[1] = '{0, 4'b1111, 3, 1, 0, 0};  // stuck at 1
        tbl[2] = '{0, 4'b0000, 1, 1, 3, 0};  // stuck at 0
        tbl[3] = '{0, 4'b0110, 3, 1, 1, 0};  // XOR gate against AND table
        tbl[4] = '{1, 4'b1000, 2, 1, 1, 0};  // and_gate against OR table
        tbl[5] = '{1, 4'b1110, 0, 0, 0, 1};  // or gate, OR table
        tbl[6] = '{2, 4'b1000, 0, 0, 0, 1};  // S=1, and_gate
        tbl[7] = '{2, 4'b0001, 2, 1, 0, 0};  // S=1, NOR gate

        rst   = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) dtt[i] = 4'b1000;
        #12;
        for (int i = 0; i < 3; i++) chk_all_zero(i, "reset");
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 8; n++) begin
            dtt[tbl[n].inst] = tbl[n].dtt;
            launch(tbl[n].inst);
            check_run(tbl[n].inst, tbl[n].e_err, tbl[n].e_ffv, tbl[n].e_vec, tbl[n].e_pass, 1'b0);
        end

        // Results of u0's last run (XOR gate) persist while idle.
        repeat (5) @(posedge clk);
        #1;
        cur = 0;
        chk("hold_err", errc(0), 3);
        chk("hold_ffv", int'(ffv[0]), 1);
        chk("hold_ffvec", ffvec(0), 1);
        chk("hold_busy", int'(busy[0]), 0);

        // S=1 with extra starts during RUN and DONE, then an identical re-run.
        dtt[2] = 4'b1011;
        model(tt_of[2], dtt[2], e_err, e_ffv, e_vec, e_pass);
        launch(2);
        check_run(2, e_err, e_ffv, e_vec, e_pass, 1'b1);
        @(posedge clk); #1;
        chk("no_requeue", int'(busy[2]), 0);
        launch(2);
        check_run(2, e_err, e_ffv, e_vec, e_pass, 1'b0);

        // Asynchronous reset in the middle of vector 10.
        dtt[0] = 4'b0000;
        launch(0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        cur = 0;
        chk("mid_vector", int'({da[0], db[0]}), 2);
        #2 rst = 1'b1;
        #1 chk_all_zero(0, "midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) begin
                cur = 0;
                chk("post_reset_idle", int'({done[0], busy[0]}), 0);
            end
        end
        chk("post_reset_idle_end", int'({done[0], busy[0]}), 0);
        dtt[0] = 4'b1000;
        launch(0);
        check_run(0, 0, 0, 0, 1, 1'b0);

        // start held high: back-to-back runs spaced 4S+2, recomputed each time.
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            dtt[1] = 4'($urandom_range(0, 15));
            model(tt_of[1], dtt[1], e_err, e_ffv, e_vec, e_pass);
            check_run(1, e_err, e_ffv, e_vec, e_pass, 1'b0);
            @(posedge clk); #1;
        end
        start[1] = 1'b0;
        repeat (20) @(posedge clk);

        // Randomised gates on random instances against the reference model.
        for (int n = 0; n < 24; n++) begin
            idx = int'($urandom_range(0, 2));
            g   = 4'($urandom_range(0, 15));
            dtt[idx] = g;
            model(tt_of[idx], g, e_err, e_ffv, e_vec, e_pass);
            launch(idx);
            check_run(idx, e_err, e_ffv, e_vec, e_pass, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
